// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: serialises a buffered strobe port (port0, priority) and a req/done port (port1) onto one register-file target bus.
module reg_bus_arbiter #(
  parameter int AW     = 7,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p0_we,
  input  logic          p0_re,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wd,
  output logic [DW-1:0] p0_rd,
  output logic          p0_overrun,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wd,
  output logic          p1_done,
  output logic [DW-1:0] p1_rd,
  output logic          tgt_we,
  output logic          tgt_re,
  output logic [AW-1:0] tgt_addr,
  output logic [DW-1:0] tgt_wd,
  input  logic [DW-1:0] tgt_rd
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          sel_q, we_q, wdone_q, ovr_q;
  logic [AW-1:0] tgt_addr_q, slot_addr_q;
  logic [DW-1:0] tgt_wd_q, slot_wd_q, p0_rd_q, p1_rd_q;
  logic          slot_full_q, slot_we_q;
  logic          strobe, take0, take1, room, cap;
  // Port1 is held off while a port0 strobe lands and during its own write-done cycle.
  always_comb begin
    strobe  = p0_we | p0_re;
    take0   = state_q == IDLE && slot_full_q;
    take1   = state_q == IDLE && !slot_full_q && !strobe && p1_req && !wdone_q;
    room    = !slot_full_q || take0;
    cap     = !reset && state_q == WAIT && cnt_q == 3'd1;
    state_d = (take0 || take1) ? ISSUE :
              state_q == ISSUE ? (we_q ? IDLE : WAIT) :
              cap ? IDLE : state_q;
    cnt_d   = state_q == ISSUE ? 3'(RD_LAT) : state_q == WAIT ? cnt_q - 3'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      we_q        <= 1'b0;
      wdone_q     <= 1'b0;
      ovr_q       <= 1'b0;
      tgt_addr_q  <= '0;
      tgt_wd_q    <= '0;
      p0_rd_q     <= '0;
      p1_rd_q     <= '0;
      slot_full_q <= 1'b0;
      slot_we_q   <= 1'b0;
      slot_addr_q <= '0;
      slot_wd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdone_q <= state_q == ISSUE && we_q && sel_q;
      if (take0 || take1) begin
        sel_q      <= take1;
        we_q       <= take0 ? slot_we_q : p1_we;
        tgt_addr_q <= take0 ? slot_addr_q : p1_addr;
        tgt_wd_q   <= take0 ? slot_wd_q : p1_wd;
      end
      if (cap && !sel_q) p0_rd_q <= tgt_rd;
      if (cap && sel_q) p1_rd_q <= tgt_rd;
      if (strobe && room) begin
        slot_full_q <= 1'b1;
        slot_we_q   <= p0_we;
        slot_addr_q <= p0_addr;
        slot_wd_q   <= p0_wd;
      end else if (take0) begin
        slot_full_q <= 1'b0;
      end
      if (strobe && !room) ovr_q <= 1'b1;
    end
  end
  assign tgt_we     = !reset && state_q == ISSUE && we_q;
  assign tgt_re     = !reset && state_q == ISSUE && !we_q;
  assign tgt_addr   = tgt_addr_q;
  assign tgt_wd     = tgt_wd_q;
  assign p1_done    = !reset && (wdone_q || (cap && sel_q));
  assign p0_rd      = (cap && !sel_q) ? tgt_rd : p0_rd_q;
  assign p1_rd      = (cap && sel_q) ? tgt_rd : p1_rd_q;
  assign p0_overrun = ovr_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: directed checks of the arbiter against a 3-cycle-latency target memory.
module tb_reg_bus_arbiter;
  localparam int AW = 7, DW = 8, RD_LAT = 3;
  logic clk = 0, reset = 1;
  logic p0_we = 0, p0_re = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_addr = '0, p1_addr = '0, tgt_addr;
  logic [DW-1:0] p0_wd = '0, p1_wd = '0, p0_rd, p1_rd, tgt_wd, tgt_rd;
  logic p0_overrun, p1_done, tgt_we, tgt_re;
  logic [DW-1:0] mem [128];
  logic [DW-1:0] pipe [3];
  int n_chk = 0, n_fail = 0, n_done = 0, d0;

  reg_bus_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .reset(reset),
    .p0_we(p0_we), .p0_re(p0_re), .p0_addr(p0_addr), .p0_wd(p0_wd),
    .p0_rd(p0_rd), .p0_overrun(p0_overrun),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wd(p1_wd),
    .p1_done(p1_done), .p1_rd(p1_rd),
    .tgt_we(tgt_we), .tgt_re(tgt_re), .tgt_addr(tgt_addr), .tgt_wd(tgt_wd),
    .tgt_rd(tgt_rd)
  );

  always #5 clk = ~clk;

  // Target: data is only valid in exactly the RD_LAT-th cycle after tgt_re, 0xEE otherwise.
  always @(posedge clk) begin
    if (tgt_we) mem[tgt_addr] <= tgt_wd;
    pipe[2] <= pipe[1];
    pipe[1] <= pipe[0];
    pipe[0] <= tgt_re ? mem[tgt_addr] : 8'hEE;
  end
  assign tgt_rd = pipe[RD_LAT-1];

  always @(negedge clk) if (p1_done) n_done++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic p0_strobe(input logic we, input logic re, input logic [6:0] a, input logic [7:0] d);
    p0_we = we; p0_re = re; p0_addr = a; p0_wd = d;
    tick();
    p0_we = 0; p0_re = 0;
  endtask

  task automatic p0_write(input logic [6:0] a, input logic [7:0] d);
    p0_strobe(1, 0, a, d);
    tick(2);
  endtask

  initial begin
    tick(2);
    reset = 0;
    check("rst_tgt_we", tgt_we, 0);
    check("rst_tgt_re", tgt_re, 0);
    check("rst_tgt_addr", tgt_addr, 0);
    check("rst_tgt_wd", tgt_wd, 0);
    check("rst_p0_rd", p0_rd, 0);
    check("rst_p1_rd", p1_rd, 0);
    check("rst_p1_done", p1_done, 0);
    check("rst_overrun", p0_overrun, 0);
    // T1: write strobe reaches the target two cycles later
    p0_strobe(1, 0, 7'h12, 8'hA5);
    check("t1_we_t1", tgt_we, 0);
    tick();
    check("t1_we_t2", tgt_we, 1);
    check("t1_re_t2", tgt_re, 0);
    check("t1_addr", tgt_addr, 7'h12);
    check("t1_wd", tgt_wd, 8'hA5);
    tick();
    check("t1_we_t3", tgt_we, 0);
    p0_write(7'h05, 8'h3C);
    p0_write(7'h40, 8'h77);
    p0_write(7'h41, 8'h99);
    // T2: port0 read, data visible 5 cycles after strobe
    d0 = n_done;
    p0_strobe(0, 1, 7'h05, 8'h00);
    tick();
    check("t2_re", tgt_re, 1);
    check("t2_addr", tgt_addr, 7'h05);
    tick(2);
    check("t2_rd_early", p0_rd, 0);
    tick();
    check("t2_rd", p0_rd, 8'h3C);
    tick();
    check("t2_rd_held", p0_rd, 8'h3C);
    check("t2_no_done", n_done - d0, 0);
    // T3: simultaneous port1 read request and port0 write
    d0 = n_done;
    p1_req = 1; p1_we = 0; p1_addr = 7'h40;
    p0_strobe(1, 0, 7'h20, 8'h55);
    tick();
    check("t3_p0_we", tgt_we, 1);
    check("t3_p0_addr", tgt_addr, 7'h20);
    tick(2);
    check("t3_p1_re", tgt_re, 1);
    check("t3_p1_addr", tgt_addr, 7'h40);
    tick(3);
    check("t3_done", p1_done, 1);
    check("t3_p1_rd", p1_rd, 8'h77);
    p1_req = 0;
    tick();
    check("t3_done_once", n_done - d0, 1);
    check("t3_p1_rd_held", p1_rd, 8'h77);
    // T5: slot consumed and refilled in the same cycle
    p0_strobe(1, 0, 7'h50, 8'h61);
    p0_strobe(1, 0, 7'h51, 8'h62);
    check("t5_a_we", tgt_we, 1);
    check("t5_a_addr", tgt_addr, 7'h50);
    check("t5_no_ovr", p0_overrun, 0);
    tick();
    check("t5_gap", tgt_we, 0);
    tick();
    check("t5_b_we", tgt_we, 1);
    check("t5_b_addr", tgt_addr, 7'h51);
    check("t5_b_wd", tgt_wd, 8'h62);
    tick();
    check("t5_no_ovr_end", p0_overrun, 0);
    // T4: two strobes during a port1 read in WAIT, second one overruns
    p1_req = 1; p1_we = 0; p1_addr = 7'h41;
    tick(2);
    p0_strobe(1, 0, 7'h30, 8'h11);
    check("t4_ovr_before", p0_overrun, 0);
    p0_strobe(1, 0, 7'h31, 8'h22);
    check("t4_ovr", p0_overrun, 1);
    check("t4_done", p1_done, 1);
    check("t4_p1_rd", p1_rd, 8'h99);
    p1_req = 0;
    tick(2);
    check("t4_first_we", tgt_we, 1);
    check("t4_first_addr", tgt_addr, 7'h30);
    check("t4_first_wd", tgt_wd, 8'h11);
    tick();
    check("t4_drop_a", tgt_we, 0);
    tick();
    check("t4_drop_b", tgt_we, 0);
    check("t4_ovr_sticky", p0_overrun, 1);
    // T6: reset during WAIT of a port1 read
    d0 = n_done;
    p1_req = 1; p1_we = 0; p1_addr = 7'h40;
    tick(2);
    reset = 1; p1_req = 0;
    check("t6_done_in_rst", p1_done, 0);
    tick();
    reset = 0;
    check("t6_p1_rd", p1_rd, 0);
    check("t6_ovr", p0_overrun, 0);
    check("t6_addr", tgt_addr, 0);
    check("t6_p0_rd", p0_rd, 0);
    tick(4);
    check("t6_no_done", n_done - d0, 0);
    check("t6_no_re", tgt_re, 0);
    p1_req = 1; p1_we = 1; p1_addr = 7'h42; p1_wd = 8'h5E;
    tick();
    check("t6_wr_we", tgt_we, 1);
    check("t6_wr_addr", tgt_addr, 7'h42);
    tick();
    check("t6_wr_done", p1_done, 1);
    p1_req = 0;
    tick();
    check("t6_wr_done_pulse", p1_done, 0);
    check("t6_no_reissue", tgt_we, 0);
    p1_req = 1; p1_we = 0; p1_addr = 7'h42;
    tick();
    check("t6_rd_re", tgt_re, 1);
    tick(2);
    check("t6_rd_not_yet", p1_done, 0);
    tick();
    check("t6_rd_done", p1_done, 1);
    check("t6_rd_data", p1_rd, 8'h5E);
    p1_req = 0;
    tick();
    check("t6_rd_held", p1_rd, 8'h5E);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
